// File: rtl/jtframe_ps2_pkg.sv
// Shared scancode constants, receiver state encoding and key-index lookup
// for the PS/2 debug keyboard path.
package jtframe_ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_LSHFT = 8'h12;
  localparam logic [7:0] SC_RSHFT = 8'h59;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_PLUS  = 8'h79;
  localparam logic [7:0] SC_MINUS = 8'h7B;
  localparam logic [7:0] SC_RST   = 8'h7C;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_F3    = 8'h04;
  localparam logic [7:0] SC_F4    = 8'h0C;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;
  localparam logic [7:0] SC_D3    = 8'h26;
  localparam logic [7:0] SC_D4    = 8'h25;
  localparam logic [7:0] SC_D5    = 8'h2E;
  localparam logic [7:0] SC_D6    = 8'h36;
  localparam logic [7:0] SC_D7    = 8'h3D;
  localparam logic [7:0] SC_D8    = 8'h3E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Bit positions in the held-key register; K_NONE marks an unmapped code
  localparam int          NKEYS    = 19;
  localparam logic [4:0]  K_LSHIFT = 5'd0;
  localparam logic [4:0]  K_RSHIFT = 5'd1;
  localparam logic [4:0]  K_LCTRL  = 5'd2;
  localparam logic [4:0]  K_RCTRL  = 5'd3;
  localparam logic [4:0]  K_PLUS   = 5'd4;
  localparam logic [4:0]  K_MINUS  = 5'd5;
  localparam logic [4:0]  K_RST    = 5'd6;
  localparam logic [4:0]  K_GFX    = 5'd7;
  localparam logic [4:0]  K_DIG    = 5'd11;
  localparam logic [4:0]  K_NONE   = 5'd31;

  function automatic logic [4:0] key_idx(input logic [7:0] code, input logic ext);
    key_idx = K_NONE;
    if (ext) begin
      if (code == SC_CTRL) key_idx = K_RCTRL;
    end else begin
      case (code)
        SC_LSHFT: key_idx = K_LSHIFT;
        SC_RSHFT: key_idx = K_RSHIFT;
        SC_CTRL:  key_idx = K_LCTRL;
        SC_PLUS:  key_idx = K_PLUS;
        SC_MINUS: key_idx = K_MINUS;
        SC_RST:   key_idx = K_RST;
        SC_F1:    key_idx = K_GFX;
        SC_F2:    key_idx = K_GFX + 5'd1;
        SC_F3:    key_idx = K_GFX + 5'd2;
        SC_F4:    key_idx = K_GFX + 5'd3;
        SC_D1:    key_idx = K_DIG;
        SC_D2:    key_idx = K_DIG + 5'd1;
        SC_D3:    key_idx = K_DIG + 5'd2;
        SC_D4:    key_idx = K_DIG + 5'd3;
        SC_D5:    key_idx = K_DIG + 5'd4;
        SC_D6:    key_idx = K_DIG + 5'd5;
        SC_D7:    key_idx = K_DIG + 5'd6;
        SC_D8:    key_idx = K_DIG + 5'd7;
        default:  key_idx = K_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/jtframe_debug_keys_if.sv
// Byte bus from the PS/2 frame receiver to the scancode decoder.
interface jtframe_debug_keys_if;
  logic [7:0] data;
  logic       stb;
  logic       err;
  logic       par_err;

  modport master (output data, stb, err, par_err);
  modport slave  (input  data, stb, err, par_err);
endinterface

// File: rtl/jtframe_ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter,
// bit FSM, mid-frame timeout and parity/stop check.
module jtframe_ps2_rx
  import jtframe_ps2_pkg::*;
#(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
)(
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  jtframe_debug_keys_if.master rx
);

  localparam int FW = $clog2(FILT + 1);

  logic [1:0]    clk_s, dat_s;
  logic [FW-1:0] fcnt;
  logic          filt, fall;
  rx_state_t     st;
  logic [2:0]    bcnt;
  logic          par;
  logic [15:0]   tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
    end
  end

  // A new level is taken only after FILT consecutive cycles of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s[1] == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT - 1)) begin
      filt <= clk_s[1];
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign fall = filt & ~clk_s[1] & (fcnt == FW'(FILT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      bcnt       <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      rx.data    <= '0;
      rx.stb     <= 1'b0;
      rx.err     <= 1'b0;
      rx.par_err <= 1'b0;
    end else begin
      rx.stb     <= 1'b0;
      rx.err     <= 1'b0;
      rx.par_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (st)
          ST_IDLE: if (!dat_s[1]) begin
            st   <= ST_DATA;
            bcnt <= '0;
          end
          ST_DATA: begin
            rx.data <= {dat_s[1], rx.data[7:1]};
            bcnt    <= bcnt + 1'b1;
            if (bcnt == 3'd7) st <= ST_PARITY;
          end
          ST_PARITY: begin
            par <= dat_s[1];
            st  <= ST_STOP;
          end
          default: begin
            st <= ST_IDLE;
            if (dat_s[1] && (^rx.data ^ par)) begin
              rx.stb <= 1'b1;
            end else begin
              rx.err     <= 1'b1;
              rx.par_err <= 1'b1;
            end
          end
        endcase
      end else if (st == ST_IDLE) begin
        tcnt <= '0;
      end else if (tcnt == 16'(TIMEOUT - 1)) begin
        rx.err <= 1'b1;
        st     <= ST_IDLE;
        tcnt   <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_debug_keys.sv
// PS/2 scancode set 2 decoder producing held-key levels for the debug
// overlay; E0/F0 prefixes tracked as flags, E1 (Pause) bytes skipped.
module jtframe_debug_keys
  import jtframe_ps2_pkg::*;
#(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       shift,
  output logic       ctrl,
  output logic       debug_plus,
  output logic       debug_minus,
  output logic       debug_rst,
  output logic [3:0] key_gfx,
  output logic [7:0] key_digit,
  output logic       byte_stb,
  output logic       frame_err
);

  jtframe_debug_keys_if bus();

  jtframe_ps2_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (bus.master)
  );

  logic             ext, brk;
  logic [2:0]       skip;
  logic [4:0]       idx;
  logic [NKEYS-1:0] keys, hit;

  assign idx = key_idx(bus.data, ext);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NKEYS; i++) hit[i] = (idx == 5'(i));
  end

  // A bad frame drops any half-received prefix; a timeout leaves it intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      skip <= '0;
      keys <= '0;
    end else if (bus.stb) begin
      if (skip != 3'd0) begin
        skip <= skip - 1'b1;
      end else if (bus.data == SC_E0) begin
        ext <= 1'b1;
      end else if (bus.data == SC_F0) begin
        brk <= 1'b1;
      end else if (bus.data == SC_E1) begin
        skip <= 3'd7;
      end else begin
        keys <= brk ? (keys & ~hit) : (keys | hit);
        ext  <= 1'b0;
        brk  <= 1'b0;
      end
    end else if (bus.par_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end
  end

  assign shift       = keys[K_LSHIFT] | keys[K_RSHIFT];
  assign ctrl        = keys[K_LCTRL]  | keys[K_RCTRL];
  assign debug_plus  = keys[K_PLUS];
  assign debug_minus = keys[K_MINUS];
  assign debug_rst   = keys[K_RST];
  assign key_gfx     = keys[K_GFX +: 4];
  assign key_digit   = keys[K_DIG +: 8];
  assign byte_stb    = bus.stb;
  assign frame_err   = bus.err;

endmodule

// File: tb/tb_jtframe_debug_keys.sv
// Directed + random PS/2 frames against a scancode-level held-key model.
module tb_jtframe_debug_keys;

  localparam int FILT    = 8;
  localparam int TIMEOUT = 1000;
  localparam int H       = 16;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_data;
  logic       shift, ctrl, debug_plus, debug_minus, debug_rst;
  logic [3:0] key_gfx;
  logic [7:0] key_digit;
  logic       byte_stb, frame_err;

  jtframe_debug_keys #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .shift(shift), .ctrl(ctrl), .debug_plus(debug_plus),
    .debug_minus(debug_minus), .debug_rst(debug_rst), .key_gfx(key_gfx),
    .key_digit(key_digit), .byte_stb(byte_stb), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int stb_cnt = 0, err_cnt = 0, exp_stb = 0, exp_err = 0;

  always @(negedge clk) begin
    if (byte_stb)  stb_cnt++;
    if (frame_err) err_cnt++;
  end

  // Model: which scancodes are currently held, plain and E0-extended
  bit   held_n[256], held_e[256];
  bit   m_ext, m_brk;
  int   m_skip;
  logic [7:0] dig_codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
  logic [7:0] gfx_codes [4] = '{8'h05, 8'h06, 8'h04, 8'h0C};
  logic [7:0] pool [22] = '{8'h12, 8'h59, 8'h14, 8'h79, 8'h7B, 8'h7C, 8'h05, 8'h06,
                            8'h04, 8'h0C, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                            8'h3D, 8'h3E, 8'hE0, 8'hF0, 8'hAA, 8'hFA};

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else begin
      if (m_ext) held_e[b] = !m_brk;
      else       held_n[b] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  function automatic logic [16:0] model_out();
    logic [3:0] g;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) g[i] = held_n[gfx_codes[i]];
    for (int i = 0; i < 8; i++) d[i] = held_n[dig_codes[i]];
    return {held_n[8'h12] | held_n[8'h59], held_n[8'h14] | held_e[8'h14],
            held_n[8'h79], held_n[8'h7B], held_n[8'h7C], g, d};
  endfunction

  wire [16:0] outs = {shift, ctrl, debug_plus, debug_minus, debug_rst, key_gfx, key_digit};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic half(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit glitch = 0);
    logic [10:0] bits;
    logic [16:0] pre;
    bit got;
    got  = 0;
    pre  = model_out();
    bits = {1'b1, ~^b ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      if (glitch && i > 0 && i < 9) begin
        half(4); ps2_clk = 0; half(3); ps2_clk = 1; half(H - 7);
      end else half(H);
      ps2_clk = 0;
      if (i < 10) half(H);
      else begin
        for (int n = 0; n < 3 * H && !got; n++) begin
          @(negedge clk);
          if (byte_stb || frame_err) got = 1;
        end
      end
      if (i < 10) ps2_clk = 1;
    end
    check($sformatf("seen_%02h", b), 32'(got), 1);
    check($sformatf("stb_%02h", b), 32'(byte_stb), 32'(!bad_par));
    check($sformatf("err_%02h", b), 32'(frame_err), 32'(bad_par));
    check($sformatf("hold_%02h", b), 32'(outs), 32'(pre));
    if (bad_par) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else begin
      model_byte(b); exp_stb++;
    end
    @(negedge clk);
    check($sformatf("keys_%02h", b), 32'(outs), 32'(model_out()));
    ps2_clk = 1;
    ps2_data = 1;
    half(2 * H);
  endtask

  task automatic send_partial();
    bit got_err, got_stb;
    got_err = 0;
    got_stb = 0;
    for (int i = 0; i < 5; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'(i & 1);
      half(H); ps2_clk = 0; half(H); ps2_clk = 1;
    end
    ps2_data = 1;
    for (int n = 0; n < TIMEOUT + 200 && !got_err; n++) begin
      @(negedge clk);
      if (frame_err) got_err = 1;
      if (byte_stb)  got_stb = 1;
    end
    check("timeout_err", 32'(got_err), 1);
    check("timeout_nostb", 32'(got_stb), 0);
    exp_err++;
    @(negedge clk);
    check("timeout_keys", 32'(outs), 32'(model_out()));
    half(2 * H);
  endtask

  initial begin
    rst_n = 0; ps2_clk = 1; ps2_data = 1;
    m_ext = 0; m_brk = 0; m_skip = 0;
    half(5);
    check("rst_keys", 32'(outs), 0);
    check("rst_stb", 32'({byte_stb, frame_err}), 0);
    rst_n = 1;
    half(20);

    send(8'h79); send(8'hF0); send(8'h79);
    send(8'h12); send(8'hE0); send(8'h14); send(8'hF0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h12); send(8'h05); send(8'h0C);
    check("gfx_1001", 32'(key_gfx), 32'h9);
    send(8'h16, 1); send(8'h3E);
    check("digit_80", 32'(key_digit), 32'h80);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h7B);
    check("minus_set", 32'(debug_minus), 1);
    send(8'hF0); send(8'h3E);
    send(8'hF0); send(8'h36);
    send(8'h79); send(8'h79);
    send_partial();
    send(8'h1E, 0, 1);
    check("digit_02", 32'(key_digit), 32'h02);
    send(8'hAA); send(8'hFA); send(8'h7C);
    send(8'hE0); send(8'h7C, 1); send(8'h14);

    for (int k = 0; k < 30; k++)
      send(pool[$urandom_range(21)], $urandom_range(7) == 0, $urandom_range(3) == 0);

    check("stb_count", 32'(stb_cnt), 32'(exp_stb));
    check("err_count", 32'(err_cnt), 32'(exp_err));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
